// File: rtl/nwc_pkg.sv
// Shared sizing, derived widths and FSM state encoding for the negacyclic NTT engine.
package nwc_pkg;
    localparam int D_WIDTH     = 32;
    localparam int DEGREE      = 128;
    localparam int BN          = 16;
    localparam int MA          = DEGREE / BN;
    localparam int K           = DEGREE / BN;
    localparam int LOG_N       = $clog2(DEGREE);
    localparam int START_DELAY = 32;

    localparam int BN_W  = $clog2(BN);
    localparam int CW    = $clog2(BN - 2);
    localparam int SW    = $clog2(LOG_N);
    localparam int BF_W  = LOG_N - 1;
    localparam int DLY_W = $clog2(START_DELAY);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EX,
        WR,
        DONE
    } state_e;
endpackage

// File: rtl/nwc_butterfly.sv
// Combinational CT butterfly: x = u + a_hi*w, y = u - a_hi*w, all mod q.
// Operands must already be reduced below q; the product is reduced exactly at full width.
module nwc_butterfly
    import nwc_pkg::*;
(
    input  logic [D_WIDTH-1:0] u,
    input  logic [D_WIDTH-1:0] a_hi,
    input  logic [D_WIDTH-1:0] w,
    input  logic [D_WIDTH-1:0] q,
    output logic [D_WIDTH-1:0] x,
    output logic [D_WIDTH-1:0] y
);
    logic [2*D_WIDTH-1:0] prod;
    logic [D_WIDTH-1:0]   v;
    logic [D_WIDTH-1:0]   sum;

    assign prod = {{D_WIDTH{1'b0}}, a_hi} * {{D_WIDTH{1'b0}}, w};
    assign v    = D_WIDTH'(prod % {{D_WIDTH{1'b0}}, q});

    // q < 2^(D_WIDTH-1) keeps u+v and u+q-v inside D_WIDTH bits.
    assign sum = u + v;
    assign x   = (sum >= q) ? sum - q : sum;
    assign y   = (u >= v) ? u - v : u + (q - v);
endmodule

// File: rtl/nwc_ntt_top.sv
// In-place negacyclic NTT: one radix-2 butterfly every 3 cycles (RD/EX/WR), done is sticky.
// Optional NWC_TOP_START_PORT_EN adds a start input replacing the START_DELAY auto-start.
module nwc_ntt_top
    import nwc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef NWC_TOP_START_PORT_EN
    input  logic               start,
`endif
    input  logic [D_WIDTH-1:0] modulus,
    output logic               done
);
    state_e              state_q;
    logic [SW-1:0]       stage_q;
    logic [BF_W-1:0]     bf_q;
`ifndef NWC_TOP_START_PORT_EN
    logic [DLY_W-1:0]    dly_q;
`endif
    logic                done_q;
    logic [D_WIDTH-1:0]  u_q, ahi_q, w_q, x_q, y_q;
    logic [D_WIDTH-1:0]  bf_x, bf_y;

    logic [SW-1:0]       sh;
    logic [LOG_N-1:0]    len, bf_ext, grp, j_lo, j_hi, t_idx;
    logic [BN_W-1:0]     tf_lo;
    logic [LOG_N-BN_W-1:0] tf_hi;
    logic [D_WIDTH-1:0]  w_sel, rd_lo, rd_hi;
    logic                wr_en, last_bf;

    // Butterfly k of a stage: group = k / len, offset = k % len, so groups run outer and j inner.
    assign sh     = SW'(LOG_N - 1) - stage_q;
    assign len    = LOG_N'(1) << sh;
    assign bf_ext = {1'b0, bf_q};
    assign grp    = bf_ext >> sh;
    assign j_lo   = ((grp << sh) << 1) | (bf_ext & (len - LOG_N'(1)));
    assign j_hi   = j_lo | len;
    assign t_idx  = (LOG_N'(1) << stage_q) | grp;
    assign tf_lo  = t_idx[BN_W-1:0];
    assign tf_hi  = t_idx[LOG_N-1:BN_W];
    assign last_bf = (stage_q == SW'(LOG_N - 1)) && (&bf_q);
    assign wr_en  = (state_q == WR) && !rst;

    if (1) begin : memory_rtl
        logic [D_WIDTH-1:0] memory_array [BN][MA];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                memory_array[j_lo[BN_W-1:0]][j_lo[LOG_N-1:BN_W]] <= x_q;
                memory_array[j_hi[BN_W-1:0]][j_hi[LOG_N-1:BN_W]] <= y_q;
            end
        end
    end

    if (1) begin : TF_gen
        logic [D_WIDTH-1:0] TF_base_array  [K][BN-1];
        logic [D_WIDTH-1:0] TF_const_array [BN-2];

        // Contents arrive by external preload; the self-hold keeps them as plain clocked storage.
        always_ff @(posedge clk) begin
            TF_base_array  <= TF_base_array;
            TF_const_array <= TF_const_array;
        end
    end

    assign rd_lo = memory_rtl.memory_array[j_lo[BN_W-1:0]][j_lo[LOG_N-1:BN_W]];
    assign rd_hi = memory_rtl.memory_array[j_hi[BN_W-1:0]][j_hi[LOG_N-1:BN_W]];
    assign w_sel = (tf_lo != '0) ? TF_gen.TF_base_array[tf_hi][tf_lo - BN_W'(1)]
                                 : TF_gen.TF_const_array[CW'(tf_hi) - CW'(1)];

    nwc_butterfly u_butterfly (
        .u    (u_q),
        .a_hi (ahi_q),
        .w    (w_q),
        .q    (modulus),
        .x    (bf_x),
        .y    (bf_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            bf_q    <= '0;
`ifndef NWC_TOP_START_PORT_EN
            dly_q   <= '0;
`endif
            done_q  <= 1'b0;
            u_q     <= '0;
            ahi_q   <= '0;
            w_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef NWC_TOP_START_PORT_EN
                    if (start) state_q <= RD;
`else
                    if (dly_q == DLY_W'(START_DELAY - 1)) state_q <= RD;
                    else dly_q <= dly_q + DLY_W'(1);
`endif
                end
                RD: begin
                    u_q     <= rd_lo;
                    ahi_q   <= rd_hi;
                    w_q     <= w_sel;
                    state_q <= EX;
                end
                EX: begin
                    x_q     <= bf_x;
                    y_q     <= bf_y;
                    state_q <= WR;
                end
                WR: begin
                    if (last_bf) begin
                        stage_q <= '0;
                        bf_q    <= '0;
                        state_q <= DONE;
                    end else begin
                        bf_q    <= bf_q + BF_W'(1);
                        if (&bf_q) stage_q <= stage_q + SW'(1);
                        state_q <= RD;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
`ifdef NWC_TOP_START_PORT_EN
                    if (start) begin
                        done_q  <= 1'b0;
                        state_q <= RD;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = done_q;
endmodule

// File: tb/tb_nwc_ntt_top.sv
// Bench for nwc_ntt_top: preloads psi_rev tables and coefficients, queues golden NTT values
// from direct negacyclic evaluation, and checks memory, done timing and reset behaviour.
module tb_nwc_ntt_top;
    import nwc_pkg::*;

    localparam longint unsigned Q = 65537;
`ifdef NWC_TOP_START_PORT_EN
    localparam int DONE_AT = 1346;
`else
    localparam int DONE_AT = 1377;
`endif

    logic               clk;
    logic               rst;
    logic [D_WIDTH-1:0] modulus;
    logic               done;
`ifdef NWC_TOP_START_PORT_EN
    logic               start;
`endif

    logic [D_WIDTH-1:0] bf_u, bf_a, bf_w, bf_q, bf_x, bf_y;

    int checks;
    int errors;
    logic [31:0] exp_q[$];
    longint unsigned psi;

    nwc_ntt_top dut (
        .clk     (clk),
        .rst     (rst),
`ifdef NWC_TOP_START_PORT_EN
        .start   (start),
`endif
        .modulus (modulus),
        .done    (done)
    );

    nwc_butterfly u_bf (
        .u    (bf_u),
        .a_hi (bf_a),
        .w    (bf_w),
        .q    (bf_q),
        .x    (bf_x),
        .y    (bf_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint unsigned mpow(input longint unsigned b, input int e);
        longint unsigned r = 1;
        longint unsigned base = b % Q;
        int ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * base) % Q;
            base = (base * base) % Q;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic int brv(input int v);
        int r = 0;
        for (int b = 0; b < LOG_N; b++)
            if (v[b]) r = r | (1 << (LOG_N - 1 - b));
        return r;
    endfunction

    // Output slot k of the bit-reversed NWC NTT holds a(psi^(2*brv(k)+1)).
    task automatic push_golden(input logic [31:0] a [DEGREE]);
        for (int k = 0; k < DEGREE; k++) begin
            longint unsigned r, acc;
            r = mpow(psi, 2 * brv(k) + 1);
            acc = 0;
            for (int j = DEGREE - 1; j >= 0; j--)
                acc = (acc * r + longint'(a[j])) % Q;
            exp_q.push_back(acc[31:0]);
        end
    endtask

    task automatic load_poly(input logic [31:0] a [DEGREE], input bit push);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < DEGREE; n++)
            dut.memory_rtl.memory_array[n % BN][n / BN] = a[n];
        if (push) push_golden(a);
        @(posedge clk); #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_counters", 32'({dut.stage_q, dut.bf_q}), 32'd0);
    endtask

    task automatic run_from_release(input int limit, output int rise);
        rise = 0;
        @(negedge clk);
        rst = 1'b0;
`ifdef NWC_TOP_START_PORT_EN
        start = 1'b1;
`endif
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
`ifdef NWC_TOP_START_PORT_EN
            start = 1'b0;
`endif
            if (done) begin
                rise = c;
                break;
            end
        end
    endtask

    task automatic check_mem(input string tag);
        for (int n = 0; n < DEGREE; n++) begin
            logic [31:0] e;
            if (exp_q.size() == 0) begin
                chk($sformatf("%s_queue_empty_%0d", tag, n), 32'd1, 32'd0);
                return;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_mem_%0d", tag, n), dut.memory_rtl.memory_array[n % BN][n / BN], e);
        end
    endtask

    initial begin
        logic [31:0] a [DEGREE];
        int rise;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        modulus = 32'(Q);
`ifdef NWC_TOP_START_PORT_EN
        start = 1'b0;
`endif
        psi = mpow(3, 65536 / (2 * DEGREE));

        for (int t = 1; t < DEGREE; t++) begin
            logic [31:0] pv;
            pv = 32'(mpow(psi, brv(t)));
            if (t % BN != 0) dut.TF_gen.TF_base_array[t / BN][t % BN - 1] = pv;
            else             dut.TF_gen.TF_const_array[t / BN - 1] = pv;
        end

        // Modular wrap corners of the butterfly itself.
        bf_q = 32'(Q);
        bf_u = 32'd65536; bf_a = 32'd65536; bf_w = 32'd65536; #1;
        chk("bf_wrap_x", bf_x, 32'd0);
        chk("bf_wrap_y", bf_y, 32'd65535);
        bf_u = 32'd0; bf_a = 32'd1; bf_w = 32'd1; #1;
        chk("bf_sub_x", bf_x, 32'd1);
        chk("bf_sub_y", bf_y, 32'd65536);
        bf_u = 32'd40000; bf_a = 32'd30000; bf_w = 32'd2; #1;
        chk("bf_mix_x", bf_x, 32'(longint'(40000 + 60000) % Q));
        chk("bf_mix_y", bf_y, 32'(longint'(40000 - 60000 + 65537)));

        // All-zero polynomial, done timing and stickiness.
        for (int n = 0; n < DEGREE; n++) a[n] = 32'd0;
        load_poly(a, 1'b1);
        run_from_release(3000, rise);
        chk("zero_done_cycle", 32'(rise), 32'(DONE_AT));
        repeat (20) @(posedge clk);
        #1;
        chk("zero_done_sticky", 32'(done), 32'd1);
        check_mem("zero");

        // Constant term only: every evaluation point yields 5.
        for (int n = 0; n < DEGREE; n++) a[n] = 32'd0;
        a[0] = 32'd5;
        load_poly(a, 1'b1);
        run_from_release(3000, rise);
        chk("const_done_cycle", 32'(rise), 32'(DONE_AT));
        check_mem("const");

        // Random coefficients including the q-1 extreme.
        for (int n = 0; n < DEGREE; n++) a[n] = 32'($urandom_range(65536, 0));
        a[1] = 32'd65536;
        load_poly(a, 1'b1);
        run_from_release(3000, rise);
        chk("rand_done_cycle", 32'(rise), 32'(DONE_AT));
        check_mem("rand");

        // Reset mid-run aborts to IDLE, then a full rerun restarts from release.
        for (int n = 0; n < DEGREE; n++) a[n] = 32'($urandom_range(65536, 0));
        load_poly(a, 1'b0);
        run_from_release(599, rise);
        chk("midrun_no_early_done", 32'(rise), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_state", 32'(dut.state_q), 32'(IDLE));
        run_from_release(3000, rise);
        chk("midrun_restart_done_cycle", 32'(rise), 32'(DONE_AT));

`ifdef NWC_TOP_START_PORT_EN
        // Without a start pulse the engine must stay idle.
        for (int n = 0; n < DEGREE; n++) a[n] = 32'd0;
        load_poly(a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("nostart_done", 32'(done), 32'd0);
        chk("nostart_state", 32'(dut.state_q), 32'(IDLE));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
